// File: rtl/ram_access_ctrl_if.sv
// Bundles the switch/key inputs and display-side outputs of ram_access_ctrl.
// fsm_state is a debug view of the controller state (0 CLEAR, 1 IDLE, 2 WRITE, 3 HOLD).
interface ram_access_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  // Handshake: a 1->0 press of wr_key_n in IDLE is the request. wr_done is the one-cycle
  // acknowledge when the write commits. No new request is taken until the key is released.
  logic [ADDR_W-1:0] wr_addr_sw;
  logic [DATA_W-1:0] wr_data_sw;
  logic              wr_key_n;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_wr_data;
  logic [DATA_W-1:0] disp_rd_data;
  logic              wr_done;
  logic              busy;
  logic [1:0]        fsm_state;

  modport master (
    output wr_addr_sw, wr_data_sw, wr_key_n,
    input  disp_addr, disp_wr_data, disp_rd_data, wr_done, busy, fsm_state
  );

  modport slave (
    input  wr_addr_sw, wr_data_sw, wr_key_n,
    output disp_addr, disp_wr_data, disp_rd_data, wr_done, busy, fsm_state
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// 32x4 RAM front end: clears memory after reset, turns debounced-free key presses into single writes.
// Define READ_SCAN_EN to auto-step the read address every SCAN_DIV cycles instead of following the switches.
module ram_access_ctrl #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int SCAN_DIV = 50000000
) (
  input logic             clk,
  input logic             reset,
  ram_access_ctrl_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [DATA_W-1:0] cap_data_q, cap_data_d;
  logic              sync1_q, sync2_q, key_prev_q;
  logic              busy_q, wr_done_q;
  logic [DATA_W-1:0] disp_wr_data_q;
  logic [DATA_W-1:0] disp_rd_data_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              press;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  assign press = key_prev_q & ~sync2_q;

  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    cap_addr_d  = cap_addr_q;
    cap_data_d  = cap_data_q;
    mem_we      = 1'b0;
    mem_waddr   = clear_cnt_q;
    mem_wdata   = '0;
    case (state_q)
      S_CLEAR: begin
        mem_we      = 1'b1;
        clear_cnt_d = clear_cnt_q + ADDR_W'(1);
        if (clear_cnt_q == ADDR_W'(DEPTH - 1)) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (press) begin
          cap_addr_d = bus.wr_addr_sw;
          cap_data_d = bus.wr_data_sw;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we    = 1'b1;
        mem_waddr = cap_addr_q;
        mem_wdata = cap_data_q;
        state_d   = S_HOLD;
      end
      S_HOLD: begin
        // Re-arm only on release so a held key yields a single write.
        if (sync2_q) state_d = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      key_prev_q     <= 1'b1;
      state_q        <= S_CLEAR;
      clear_cnt_q    <= '0;
      cap_addr_q     <= '0;
      cap_data_q     <= '0;
      busy_q         <= 1'b0;
      wr_done_q      <= 1'b0;
      disp_wr_data_q <= '0;
    end else begin
      sync1_q        <= bus.wr_key_n;
      sync2_q        <= sync1_q;
      key_prev_q     <= sync2_q;
      state_q        <= state_d;
      clear_cnt_q    <= clear_cnt_d;
      cap_addr_q     <= cap_addr_d;
      cap_data_q     <= cap_data_d;
      busy_q         <= (state_q == S_CLEAR);
      wr_done_q      <= (state_q == S_WRITE);
      disp_wr_data_q <= bus.wr_data_sw;
    end
  end

  // Reset blocks the write so an uncommitted WRITE is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read returns the pre-write value on a same-cycle collision.
  always_ff @(posedge clk) begin
    if (reset) disp_rd_data_q <= '0;
    else       disp_rd_data_q <= mem[rd_addr_q];
  end

`ifdef READ_SCAN_EN
  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  logic [PW-1:0] presc_q;

  always_ff @(posedge clk) begin
    if (reset || state_q == S_CLEAR) begin
      presc_q   <= '0;
      rd_addr_q <= '0;
    end else if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_q   <= '0;
      rd_addr_q <= rd_addr_q + ADDR_W'(1);
    end else begin
      presc_q   <= presc_q + PW'(1);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) rd_addr_q <= '0;
    else       rd_addr_q <= bus.wr_addr_sw;
  end
`endif

  assign bus.disp_addr    = rd_addr_q;
  assign bus.disp_wr_data = disp_wr_data_q;
  assign bus.disp_rd_data = disp_rd_data_q;
  assign bus.wr_done      = wr_done_q;
  assign bus.busy         = busy_q;
  assign bus.fsm_state    = state_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl: clear sequence, key-to-write latency, hold, reset corner cases.
module tb_ram_access_ctrl;
`ifdef READ_SCAN_EN
  localparam int TB_SCAN_DIV = 4;
`else
  localparam int TB_SCAN_DIV = 50000000;
`endif
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  ram_access_ctrl_if #(.ADDR_W(5), .DATA_W(4)) bus();

  ram_access_ctrl #(.ADDR_W(5), .DATA_W(4), .SCAN_DIV(TB_SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // driver tasks
  task automatic press(input logic [4:0] a, input logic [3:0] d, input int low_cyc,
                       input int high_cyc, output int pulses);
    pulses = 0;
    bus.wr_addr_sw = a;
    bus.wr_data_sw = d;
    bus.wr_key_n   = 1'b0;
    repeat (low_cyc) begin
      tick();
      if (bus.wr_done) pulses++;
    end
    bus.wr_key_n = 1'b1;
    repeat (high_cyc) begin
      tick();
      if (bus.wr_done) pulses++;
    end
  endtask

  task automatic read_mem(input logic [4:0] a, output logic [3:0] d, output bit ok);
    ok = 1'b0;
    bus.wr_addr_sw = a;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.disp_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
    d = bus.disp_rd_data;
  endtask

  task automatic wait_idle(input string tag);
    int i;
    for (i = 0; i < 80; i++) begin
      if (!bus.busy) break;
      tick();
    end
    if (i == 80) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: busy still %0d after 80 cycles, required 0", tag, bus.busy);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    int busy_cnt, done_cnt;
    logic [3:0] d;
    bit ok;
    bus.wr_addr_sw = 5'h07;
    bus.wr_data_sw = 4'h5;
    bus.wr_key_n   = 1'b1;
    reset = 1'b1;
    tick(); tick();
    n_cmp++;
    if ({bus.busy, bus.wr_done, bus.disp_addr, bus.disp_wr_data, bus.disp_rd_data} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%0d done=%0d addr=%h wd=%h rd=%h, required all 0",
               bus.busy, bus.wr_done, bus.disp_addr, bus.disp_wr_data, bus.disp_rd_data);
    end
    reset = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 0) begin
        n_cmp++;
        if (bus.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL busy_first: got %0d, required 1", bus.busy);
        end
        n_cmp++;
        if (bus.disp_wr_data !== 4'h5) begin
          n_fail++;
          $display("FAIL disp_wr_data: got %h, required 5", bus.disp_wr_data);
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.wr_done) done_cnt++;
    end
    n_cmp++;
    if (busy_cnt != 32) begin
      n_fail++;
      $display("FAIL busy_len: got %0d cycles, required 32", busy_cnt);
    end
    n_cmp++;
    if (done_cnt != 0) begin
      n_fail++;
      $display("FAIL clear_wr_done: got %0d pulses, required 0", done_cnt);
    end
    for (int a = 0; a < 32; a++) begin
      read_mem(5'(a), d, ok);
      n_cmp++;
      if (!ok || d !== 4'h0) begin
        n_fail++;
        $display("FAIL clear_mem[%0d]: got %h (addr ok=%0d), required 0", a, d, ok);
      end
    end
  endtask

  task automatic test_write_latency();
    int pulses, at;
    logic [3:0] d;
    bit ok;
    pulses = 0;
    at = -1;
    bus.wr_addr_sw = 5'h13;
    bus.wr_data_sw = 4'hA;
    tick(); tick(); tick();
    bus.wr_key_n = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 11) bus.wr_key_n = 1'b1;
      tick();
      if (bus.wr_done) begin
        pulses++;
        at = i;
      end
`ifndef READ_SCAN_EN
      if (i == 5) begin
        n_cmp++;
        if (bus.disp_rd_data !== 4'hA) begin
          n_fail++;
          $display("FAIL rd_after_write: got %h, required a", bus.disp_rd_data);
        end
      end
`endif
    end
    n_cmp++;
    if (pulses != 1 || at != 4) begin
      n_fail++;
      $display("FAIL wr_done_latency: %0d pulses at cycle %0d, required 1 at cycle 4", pulses, at);
    end
    read_mem(5'h13, d, ok);
    n_cmp++;
    if (!ok || d !== 4'hA) begin
      n_fail++;
      $display("FAIL mem13_a: got %h, required a", d);
    end
  endtask

  task automatic test_long_hold();
    int pulses, p2;
    logic [3:0] d;
    bit ok;
    pulses = 0;
    bus.wr_addr_sw = 5'h13;
    bus.wr_data_sw = 4'hA;
    bus.wr_key_n   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 6) bus.wr_data_sw = 4'h3;
      tick();
      if (bus.wr_done) pulses++;
    end
    bus.wr_key_n = 1'b1;
    repeat (6) begin
      tick();
      if (bus.wr_done) pulses++;
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL hold_pulses: got %0d, required 1", pulses);
    end
    read_mem(5'h13, d, ok);
    n_cmp++;
    if (!ok || d !== 4'hA) begin
      n_fail++;
      $display("FAIL hold_value: got %h, required a", d);
    end
    press(5'h13, 4'h3, 5, 6, p2);
    n_cmp++;
    if (p2 != 1) begin
      n_fail++;
      $display("FAIL repress_pulses: got %0d, required 1", p2);
    end
    read_mem(5'h13, d, ok);
    n_cmp++;
    if (!ok || d !== 4'h3) begin
      n_fail++;
      $display("FAIL repress_value: got %h, required 3", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] addrs [3];
    logic [3:0] datas [3];
    int pulses;
    logic [3:0] d;
    bit ok;
    addrs = '{5'h00, 5'h1F, 5'h07};
    datas = '{4'h1, 4'hF, 4'h9};
    for (int i = 0; i < 3; i++) begin
      press(addrs[i], datas[i], 4, 4, pulses);
      n_cmp++;
      if (pulses != 1) begin
        n_fail++;
        $display("FAIL b2b_pulses[%0d]: got %0d, required 1", i, pulses);
      end
    end
    for (int i = 0; i < 3; i++) begin
      read_mem(addrs[i], d, ok);
      n_cmp++;
      if (!ok || d !== datas[i]) begin
        n_fail++;
        $display("FAIL b2b_value[%h]: got %h, required %h", addrs[i], d, datas[i]);
      end
    end
    read_mem(5'h13, d, ok);
    n_cmp++;
    if (!ok || d !== 4'h3) begin
      n_fail++;
      $display("FAIL b2b_untouched: got %h, required 3", d);
    end
  endtask

  task automatic test_press_in_clear();
    int pulses;
    logic [3:0] d;
    bit ok;
    pulses = 0;
    bus.wr_addr_sw = 5'h05;
    bus.wr_data_sw = 4'hC;
    do_reset();
    for (int i = 0; i < 45; i++) begin
      if (i == 10) bus.wr_key_n = 1'b0;
      if (i == 15) bus.wr_key_n = 1'b1;
      tick();
      if (bus.wr_done) pulses++;
    end
    wait_idle("clear_press_idle");
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL clear_press_pulses: got %0d, required 0", pulses);
    end
    for (int a = 0; a < 32; a++) begin
      read_mem(5'(a), d, ok);
      n_cmp++;
      if (!ok || d !== 4'h0) begin
        n_fail++;
        $display("FAIL clear_press_mem[%0d]: got %h, required 0", a, d);
      end
    end
  endtask

  task automatic test_reset_in_write();
    bit found;
    logic [3:0] d;
    bit ok;
    int pulses;
    press(5'h09, 4'h6, 4, 4, pulses);
    found = 1'b0;
    bus.wr_addr_sw = 5'h09;
    bus.wr_data_sw = 4'h2;
    bus.wr_key_n   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fsm_state == ST_WRITE) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_write: state %0d, required %0d within 10 cycles", bus.fsm_state, ST_WRITE);
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus.wr_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_write: done=%0d busy=%0d, required 0 0", bus.wr_done, bus.busy);
    end
    reset = 1'b0;
    bus.wr_key_n = 1'b1;
    tick();
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_rise: got %0d, required 1", bus.busy);
    end
    wait_idle("reclear_idle");
    read_mem(5'h09, d, ok);
    n_cmp++;
    if (!ok || d !== 4'h0) begin
      n_fail++;
      $display("FAIL reclear_mem9: got %h, required 0", d);
    end
  endtask

`ifdef READ_SCAN_EN
  task automatic test_scan();
    int pulses;
    bit found;
    logic [4:0] prev;
    press(5'h1F, 4'hF, 4, 4, pulses);
    press(5'h00, 4'h1, 4, 4, pulses);
    found = 1'b0;
    prev = bus.disp_addr;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (bus.disp_addr == 5'h1F && prev != 5'h1F) begin
        found = 1'b1;
        break;
      end
      prev = bus.disp_addr;
    end
    n_cmp++;
    if (!found) begin
      n_fail++;
      $display("FAIL scan_reach31: addr %h, required 1f within 300 cycles", bus.disp_addr);
    end
    tick();
    n_cmp++;
    if (bus.disp_rd_data !== 4'hF) begin
      n_fail++;
      $display("FAIL scan_rd31: got %h, required f", bus.disp_rd_data);
    end
    tick(); tick();
    n_cmp++;
    if (bus.disp_addr !== 5'h1F) begin
      n_fail++;
      $display("FAIL scan_hold31: got %h, required 1f", bus.disp_addr);
    end
    tick();
    n_cmp++;
    if (bus.disp_addr !== 5'h00) begin
      n_fail++;
      $display("FAIL scan_wrap: got %h, required 00", bus.disp_addr);
    end
    tick();
    n_cmp++;
    if (bus.disp_rd_data !== 4'h1) begin
      n_fail++;
      $display("FAIL scan_rd0: got %h, required 1", bus.disp_rd_data);
    end
  endtask
`endif

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.wr_key_n   = 1'b1;
    bus.wr_addr_sw = '0;
    bus.wr_data_sw = '0;
    @(negedge clk);
    test_reset();
    test_write_latency();
    test_long_hold();
    test_back_to_back();
    test_press_in_clear();
    test_reset_in_write();
`ifdef READ_SCAN_EN
    test_scan();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
- Upstream stage for the hex display driver in the Lab 2 RAM task.
- Owns a 32x4 memory and converts raw switch and key inputs into clean write operations.
- Produces the address, write-data and read-data nibbles that the display driver renders on HEX5/HEX4, HEX2 and HEX0.
- Clears memory after reset; optionally auto-scans the read address.

Parameters:
ADDR_W, 5, address width; memory depth = 2**ADDR_W
DATA_W, 4, data word width
SCAN_DIV, 50000000, clock cycles per read-address step (scan feature only); legal range >= 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
wr_addr_sw  input  ADDR_W  write address from switches (static, not synchronized)
wr_data_sw  input  DATA_W  write data from switches (static, not synchronized)
wr_key_n  input  1  raw active-low write pushbutton, asynchronous to clk
disp_addr  output  ADDR_W  address to display
disp_wr_data  output  DATA_W  write-data nibble to display (registered copy of wr_data_sw)
disp_rd_data  output  DATA_W  memory contents at the current read address
wr_done  output  1  one-cycle pulse when a write commits
busy  output  1  high while the memory-clear sequence runs

Behaviour:
- Clock and reset: one clock domain, `clk`. `reset` is synchronous and active-high, sampled on the rising edge.
- Reset values: all outputs 0; busy = 1 in the cycle after reset deasserts; FSM enters CLEAR; clear counter = 0; scan counter and read address = 0.
- Key conditioning:
  - wr_key_n passes through a 2-flop synchronizer, then an edge detector.
  - A press is a 1->0 transition of the synchronized signal.
  - The synchronizer flops reset to 1 (released).
- FSM states:
  - CLEAR: writes 0 to address clear_cnt each cycle; clear_cnt increments. After address 2**ADDR_W-1 is written (32 cycles), go to IDLE and drop busy. Presses during CLEAR are ignored entirely, with no queuing.
  - IDLE: on a press, capture wr_addr_sw and wr_data_sw, then go to WRITE.
  - WRITE: one cycle. Memory[captured addr] <= captured data; wr_done = 1. Then go to HOLD.
  - HOLD: wait until the synchronized key reads 1 (released), then go to IDLE. A single press therefore yields exactly one write, however long it is held.
- Reset mid-operation: reset in any state returns to CLEAR. A write not yet committed is dropped. Memory is re-cleared.
- Memory read:
  - Synchronous read, 1-cycle latency: disp_rd_data = mem[rd_addr] registered.
  - A write and read to the same address in the same cycle returns the old value. The new value appears on the following cycle.
- disp_wr_data: registered every cycle from wr_data_sw (1-cycle latency).
- Widths: all counters are unsigned. The address wraps 2**ADDR_W-1 -> 0 with no overflow flag.

Optional Feature:
- Macro: READ_SCAN_EN
- Defined:
  - A prescaler counts 0..SCAN_DIV-1. At its terminal count, rd_addr increments (31 -> 0 wrap) and the prescaler returns to 0.
  - disp_addr = rd_addr.
  - The prescaler and rd_addr hold at 0 during CLEAR and start in IDLE.
- Undefined:
  - No prescaler.
  - rd_addr = wr_addr_sw, registered once, so disp_rd_data lags a switch change by 2 cycles.
  - disp_addr = wr_addr_sw, registered.

Test Plan:
- Reset for 1 cycle, then release -> busy high for exactly 32 cycles; wr_done stays 0; afterward every address reads 0.
- Post-clear, wr_addr_sw=5'h13, wr_data_sw=4'hA, wr_key_n low for 10 cycles -> wr_done pulses once, 4 cycles after the falling edge (2 sync + edge + WRITE); without READ_SCAN_EN, disp_rd_data = 4'hA two cycles after the write.
- Hold wr_key_n low for 100 cycles while changing wr_data_sw to 4'h3 -> only one write (value 4'hA); the second write happens only after release and a new press.
- Press wr_key_n during CLEAR (cycle 10) -> no write, no wr_done; memory all 0 after busy falls.
- With READ_SCAN_EN and SCAN_DIV=4, preload addr 31=4'hF and addr 0=4'h1 -> disp_addr steps every 4 cycles, wraps 31->0, and disp_rd_data shows F then 1 one cycle after each address change.
- Assert reset on the cycle the FSM is in WRITE -> the write is not committed, busy rises, and memory reads 0 after the clear completes.
